// File: rtl/button_scen_gen_pkg.sv
// Shared definitions for the button debounce / scan-enable generator:
// one-hot channel state encoding, button bit indices and a sizing helper.
package button_scen_gen_pkg;

    // One-hot per-channel debouncer state.
    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_WQ   = 5'b00010,
        ST_SCEN = 5'b00100,
        ST_HOLD = 5'b01000,
        ST_WFR  = 5'b10000
    } btn_state_t;

    // Bit positions of each direction within PBs / DPBs / SCENs / MCENs.
    localparam int UP      = 0;
    localparam int DOWN    = 1;
    localparam int LEFT    = 2;
    localparam int RIGHT   = 3;
    localparam int NUM_BTN = 4;

    // Largest of three timing parameters; sizes the shared channel counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: 2-flop synchronizer, debounce FSM and auto-repeat timer.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | button released, waiting for a high sync level
// WQ      | high seen, waiting for it to stay quiet for DEBOUNCE_CYCLES
// SCEN    | press accepted; single-cycle SCEN/MCEN
// HOLD    | held; timing the first repeat delay, then the repeat period
// WFR     | low seen while held, waiting for a quiet release
//
// A high level in WFR returns to HOLD rather than IDLE, so release bounce
// never re-fires SCEN; rep survives that bounce so the repeat cadence
// keeps its current phase length.
module button_debouncer
    import button_scen_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic pb,
    output logic dpb,
    output logic scen,
    output logic mcen
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync_a;
    logic             sync_b;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             rep;

    // Two-flop synchronizer on the raw asynchronous button input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= pb;
            sync_b <= sync_a;
        end
    end

    // Debounce / repeat FSM with registered DPB, SCEN and MCEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rep   <= 1'b0;
            dpb   <= 1'b0;
            scen  <= 1'b0;
            mcen  <= 1'b0;
        end else begin
            scen <= 1'b0;
            mcen <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dpb <= 1'b0;
                    if (sync_b) begin
                        state <= ST_WQ;
                        cnt   <= '0;
                    end
                end
                ST_WQ: begin
                    if (!sync_b) begin
                        state <= ST_IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_SCEN;
                        dpb   <= 1'b1;
                        scen  <= 1'b1;
                        mcen  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SCEN: begin
                    state <= ST_HOLD;
                    cnt   <= '0;
                    rep   <= 1'b0;
                    dpb   <= 1'b1;
                end
                ST_HOLD: begin
                    dpb <= 1'b1;
                    if (!sync_b) begin
                        state <= ST_WFR;
                        cnt   <= '0;
                    end else if (cnt == (rep ? PERIOD_LAST : DELAY_LAST)) begin
                        mcen <= 1'b1;
                        cnt  <= '0;
                        rep  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WFR: begin
                    if (sync_b) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                        dpb   <= 1'b1;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        dpb   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        dpb <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    rep   <= 1'b0;
                    dpb   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_scen_gen.sv
// Four independent debounced button channels (up, down, left, right)
// producing debounced levels, single press enables and auto-repeat enables.
module button_scen_gen
    import button_scen_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] PBs,
    output logic [3:0] DPBs,
    output logic [3:0] SCENs,
    output logic [3:0] MCENs
);

    // One debouncer per button bit; channels share nothing but clock and reset.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .pb   (PBs[i]),
            .dpb  (DPBs[i]),
            .scen (SCENs[i]),
            .mcen (MCENs[i])
        );
    end

endmodule

// File: tb/tb_button_scen_gen.sv
// Self-checking bench: directed scenarios followed by random button activity,
// compared every cycle against a run-length reference model.
module tb_button_scen_gen;

    localparam int D  = 4;
    localparam int RD = 6;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] PBs;
    logic [3:0] DPBs, SCENs, MCENs;

    always #5 clk = ~clk;

    button_scen_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .PBs  (PBs),
        .DPBs (DPBs),
        .SCENs(SCENs),
        .MCENs(MCENs)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b want %b", tag, $time, obs, exp);
        end
    endtask

    // Reference model: per channel, a released/accepted/held phase with run
    // lengths of consecutive synchronized high and low samples.
    typedef enum {M_REL, M_SCEN, M_HELD} mphase_t;
    mphase_t    ph[4];
    int         one_run[4];
    int         zero_run[4];
    bit         rep_m[4];
    bit         s1[4], s2[4];
    logic [3:0] pulse;
    logic [3:0] m_dpb = '0, m_scen = '0, m_mcen = '0;
    int         scen_seen = 0, rep_seen = 0;

    always @(posedge clk) begin
        pulse = '0;
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                ph[i] = M_REL; one_run[i] = 0; zero_run[i] = 0;
                rep_m[i] = 0; s1[i] = 0; s2[i] = 0;
            end else begin
                case (ph[i])
                    M_REL: begin
                        if (s2[i]) begin
                            one_run[i]++;
                            if (one_run[i] == D + 1) begin
                                ph[i] = M_SCEN; one_run[i] = 0;
                            end
                        end else one_run[i] = 0;
                    end
                    M_SCEN: begin
                        ph[i] = M_HELD; one_run[i] = 0; zero_run[i] = 0; rep_m[i] = 0;
                    end
                    default: begin
                        if (s2[i]) begin
                            if (zero_run[i] > 0) begin
                                zero_run[i] = 0; one_run[i] = 0;
                            end else begin
                                one_run[i]++;
                                if (one_run[i] == (rep_m[i] ? RP : RD)) begin
                                    pulse[i] = 1'b1; one_run[i] = 0; rep_m[i] = 1;
                                end
                            end
                        end else begin
                            one_run[i] = 0;
                            zero_run[i]++;
                            if (zero_run[i] == D + 1) begin
                                ph[i] = M_REL; zero_run[i] = 0;
                            end
                        end
                    end
                endcase
                s2[i] = s1[i];
                s1[i] = PBs[i];
            end
            m_dpb[i]  = (ph[i] != M_REL);
            m_scen[i] = (ph[i] == M_SCEN);
            m_mcen[i] = m_scen[i] | pulse[i];
            if (m_scen[i]) scen_seen++;
            if (pulse[i])  rep_seen++;
        end
    end

    task automatic cycle(input logic [3:0] pb, input logic rst);
        @(negedge clk);
        chk("DPBs",  DPBs,  m_dpb);
        chk("SCENs", SCENs, m_scen);
        chk("MCENs", MCENs, m_mcen);
        PBs   = pb;
        reset = rst;
    endtask

    task automatic hold(input logic [3:0] pb, input int n);
        for (int c = 0; c < n; c++) cycle(pb, 1'b0);
    endtask

    logic [3:0] lvl;
    int         seg[4];

    initial begin
        reset = 1'b1;
        PBs   = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_dpb",  DPBs,  4'b0000);
        chk("reset_scen", SCENs, 4'b0000);
        chk("reset_mcen", MCENs, 4'b0000);
        reset = 1'b0;

        hold(4'b0001, 20); hold(4'b0000, 15);            // single press
        hold(4'b0100, 3);  hold(4'b0000, 12);            // short glitch
        hold(4'b1000, 30); hold(4'b0000, 15);            // auto-repeat
        hold(4'b0010, 20); hold(4'b0000, 2);             // release bounce
        hold(4'b0010, 2);  hold(4'b0000, 15);
        hold(4'b1001, 20); hold(4'b0000, 15);            // simultaneous
        hold(4'b0001, 15);                               // reset mid-hold
        cycle(4'b0001, 1'b1); cycle(4'b0001, 1'b1);
        hold(4'b0001, 20); hold(4'b0000, 15);

        lvl = '0;
        for (int i = 0; i < 4; i++) seg[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (seg[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    seg[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(1, 40);
                end
                seg[i]--;
            end
            cycle(lvl, ($urandom_range(0, 499) == 0));
        end
        hold(4'b0000, 15);

        if (scen_seen == 0 || rep_seen == 0) begin
            n_err++;
            $display("FAIL coverage: scen=%0d repeats=%0d required nonzero", scen_seen, rep_seen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
